// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC ownership, request/ack memory handshake,
// redirect with in-flight drop, and a 1-entry skid buffer toward decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_err
);
  typedef enum logic [1:0] {REQ, DRAIN, HOLD} state_t;
  state_t      state;
  logic        running;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] target;
  logic [31:0] next_addr;
  logic        slot_free;
  assign target    = {redirect_pc[31:2], 2'b00};
  assign next_addr = fetch_addr + 32'd4;
  assign slot_free = !if_valid || !stall;
  // running stays low for the first edge after reset so the bus is idle during reset
  assign imem_ren  = running && state != HOLD;
  assign imem_addr = running ? fetch_addr : 32'd0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= REQ;
      running     <= 1'b0;
      pc          <= RESET_PC;
      fetch_addr  <= RESET_PC;
      skid_instr  <= 32'd0;
      skid_pc     <= 32'd0;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= 32'd0;
      if_pc_plus4 <= 32'd0;
      fetch_err   <= 1'b0;
    end else if (!running) begin
      running <= 1'b1;
    end else if (redirect) begin
      pc       <= target;
      if_valid <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) fetch_err <= 1'b1;
      // an unacked request must stay on the bus until the memory completes it
      if (state != HOLD && !imem_ack) begin
        state <= DRAIN;
      end else begin
        state      <= REQ;
        fetch_addr <= target;
      end
    end else begin
      case (state)
        REQ: begin
          if (imem_ack && slot_free) begin
            if_instr    <= imem_rdata;
            if_pc       <= fetch_addr;
            if_pc_plus4 <= next_addr;
            if_valid    <= 1'b1;
            pc          <= next_addr;
            fetch_addr  <= next_addr;
          end else if (imem_ack) begin
            skid_instr <= imem_rdata;
            skid_pc    <= fetch_addr;
            pc         <= next_addr;
            state      <= HOLD;
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_instr    <= skid_instr;
            if_pc       <= skid_pc;
            if_pc_plus4 <= skid_pc + 32'd4;
            if_valid    <= 1'b1;
            fetch_addr  <= pc;
            state       <= REQ;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            fetch_addr <= pc;
            state      <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors with hand-computed expectations for fetch_stage.
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_err;
  int checks = 0;
  int errors = 0;
  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .fetch_err(fetch_err)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_5A00;
  endfunction
  assign imem_rdata = mem(imem_addr);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic out(input string tag, input logic v, input logic [31:0] p);
    check({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
    if (v) begin
      check({tag, "_pc"}, if_pc, p);
      check({tag, "_pc4"}, if_pc_plus4, p + 32'd4);
      check({tag, "_instr"}, if_instr, mem(p));
    end
  endtask
  task automatic bus(input string tag, input logic ren, input logic [31:0] a);
    check({tag, "_ren"}, {31'd0, imem_ren}, {31'd0, ren});
    check({tag, "_addr"}, imem_addr, a);
  endtask
  initial begin
    #3;
    bus("rst", 1'b0, 32'h0);
    out("rst", 1'b0, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    step; step;
    reset = 1'b1;
    imem_ack = 1'b1;
    step;
    bus("t1_start", 1'b1, 32'h0);
    out("t1_start", 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step;
      out("t1_seq", 1'b1, 32'(i * 4));
      bus("t1_seq", 1'b1, 32'(i * 4 + 4));
    end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      out("t3_hold", 1'b1, 32'h8);
      check("t3_ren", {31'd0, imem_ren}, 32'd0);
    end
    stall = 1'b0;
    step;
    out("t3_skid", 1'b1, 32'hC);
    bus("t3_skid", 1'b1, 32'h10);
    step;
    out("t3_next", 1'b1, 32'h10);
    for (int r = 0; r < 2; r++) begin
      imem_ack = 1'b0;
      step;
      out("t2_gap1", 1'b0, 32'h0);
      step;
      out("t2_gap2", 1'b0, 32'h0);
      imem_ack = 1'b1;
      step;
      out("t2_ack", 1'b1, 32'(20 + r * 4));
    end
    imem_ack = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step;
    bus("t4_drain", 1'b1, 32'h1C);
    out("t4_drain", 1'b0, 32'h0);
    redirect = 1'b0;
    step;
    bus("t4_wait", 1'b1, 32'h1C);
    imem_ack = 1'b1;
    step;
    out("t4_drop", 1'b0, 32'h0);
    bus("t4_new", 1'b1, 32'h40);
    step;
    out("t4_tgt", 1'b1, 32'h40);
    check("t4_err", {31'd0, fetch_err}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h82;
    step;
    check("t5_err", {31'd0, fetch_err}, 32'd1);
    bus("t5_addr", 1'b1, 32'h80);
    out("t5_flush", 1'b0, 32'h0);
    redirect = 1'b0;
    step;
    out("t5_tgt", 1'b1, 32'h80);
    check("t5_sticky", {31'd0, fetch_err}, 32'd1);
    stall = 1'b1;
    step;
    out("flush_hold", 1'b1, 32'h80);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step;
    out("flush_stall", 1'b0, 32'h0);
    bus("flush_stall", 1'b1, 32'h100);
    redirect = 1'b0;
    stall = 1'b0;
    step;
    out("flush_tgt", 1'b1, 32'h100);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step;
    bus("wrap_req", 1'b1, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step;
    out("wrap_top", 1'b1, 32'hFFFF_FFFC);
    check("wrap_pc4", if_pc_plus4, 32'h0);
    bus("wrap_next", 1'b1, 32'h0);
    step;
    out("wrap_zero", 1'b1, 32'h0);
    stall = 1'b1;
    step;
    check("t6_hold_ren", {31'd0, imem_ren}, 32'd0);
    #2 reset = 1'b0;
    #1;
    bus("t6_rst_hold", 1'b0, 32'h0);
    out("t6_rst_hold", 1'b0, 32'h0);
    check("t6_rst_pc", if_pc, 32'h0);
    check("t6_rst_err", {31'd0, fetch_err}, 32'd0);
    step;
    reset = 1'b1;
    stall = 1'b0;
    step;
    bus("t6_restart", 1'b1, 32'h0);
    step;
    out("t6_first", 1'b1, 32'h0);
    imem_ack = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step;
    bus("t6_drain", 1'b1, 32'h4);
    redirect = 1'b0;
    #2 reset = 1'b0;
    #1;
    bus("t6_rst_drain", 1'b0, 32'h0);
    out("t6_rst_drain", 1'b0, 32'h0);
    step;
    reset = 1'b1;
    imem_ack = 1'b1;
    step;
    bus("t6_restart2", 1'b1, 32'h0);
    step;
    out("t6_first2", 1'b1, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
